eth_pause_gen: RTL and testbench



---
 rtl/ofs_fim_eth_plat_if_pkg.sv | 12 +
 rtl/eth_sat_cnt.sv | 21 ++
 rtl/eth_pause_gen.sv | 132 +++++++++++++
 tb/tb_eth_pause_gen.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ofs_fim_eth_plat_if_pkg.sv
// rtl/ofs_fim_eth_plat_if_pkg.sv - Ethernet platform sideband types shared with the MAC
package ofs_fim_eth_plat_if_pkg;

  localparam int ETH_PFC_PRIO = 8;

  typedef struct packed {
    logic                    pause_xoff;
    logic                    pause_xon;
    logic [ETH_PFC_PRIO-1:0] pfc_xoff;
  } t_eth_sideband_to_mac;

endpackage

// File: rtl/eth_sat_cnt.sv
// rtl/eth_sat_cnt.sv - 32-bit event counter that holds at all-ones
module eth_sat_cnt (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_inc,
  output logic [31:0] o_cnt
);

  logic [31:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/eth_pause_gen.sv
// rtl/eth_pause_gen.sv - link pause XOFF/XON generator with hysteresis and refresh, plus PFC forwarding
module eth_pause_gen
  import ofs_fim_eth_plat_if_pkg::*;
#(
  parameter int OCC_WIDTH      = 12,
  parameter int XOFF_THRESH    = 768,
  parameter int XON_THRESH     = 256,
  parameter int REFRESH_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_pause_en,
  input  logic [ETH_PFC_PRIO-1:0] cfg_pfc_en,
  input  logic [OCC_WIDTH-1:0]    rx_occ,
  input  logic [ETH_PFC_PRIO-1:0] pfc_req,
  output t_eth_sideband_to_mac    sb_to_mac,
  output logic                    paused,
  output logic [31:0]             xoff_cnt,
  output logic [31:0]             xon_cnt
);

  if (XON_THRESH >= XOFF_THRESH) begin : g_bad_hyst
    $error("eth_pause_gen: XON_THRESH must be below XOFF_THRESH");
  end
  if ((XON_THRESH < 0) || (XOFF_THRESH >= (1 << OCC_WIDTH))) begin : g_bad_width
    $error("eth_pause_gen: thresholds do not fit in OCC_WIDTH");
  end
  if ((REFRESH_CYCLES < 2) || (REFRESH_CYCLES > 65535)) begin : g_bad_refresh
    $error("eth_pause_gen: REFRESH_CYCLES out of range 2..65535");
  end

  localparam logic [OCC_WIDTH-1:0] XOFF_T       = OCC_WIDTH'(XOFF_THRESH);
  localparam logic [OCC_WIDTH-1:0] XON_T        = OCC_WIDTH'(XON_THRESH);
  localparam logic [15:0]          REFRESH_LOAD = 16'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XOFF,
    S_PAUSED,
    S_XON
  } t_state;

  t_state                  r_state;
  t_state                  w_next_state;
  logic [15:0]             r_refresh_cnt;
  logic [15:0]             w_refresh_nxt;
  logic                    r_pause_xoff;
  logic                    r_pause_xon;
  logic                    r_paused;
  logic [ETH_PFC_PRIO-1:0] r_pfc_xoff;
  logic                    w_pause_xoff;
  logic                    w_pause_xon;
  logic                    w_paused;
  logic                    w_xon_cond;

  assign w_xon_cond = !cfg_pause_en || (rx_occ <= XON_T);

  // Outputs are decoded from the next state and registered, so they line up with r_state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_refresh_cnt <= '0;
      r_pause_xoff  <= 1'b0;
      r_pause_xon   <= 1'b0;
      r_paused      <= 1'b0;
      r_pfc_xoff    <= '0;
    end else begin
      r_state       <= w_next_state;
      r_refresh_cnt <= w_refresh_nxt;
      r_pause_xoff  <= w_pause_xoff;
      r_pause_xon   <= w_pause_xon;
      r_paused      <= w_paused;
      r_pfc_xoff    <= pfc_req & cfg_pfc_en;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_refresh_nxt = r_refresh_cnt;
    case (r_state)
      S_IDLE: begin
        if (cfg_pause_en && (rx_occ >= XOFF_T)) w_next_state = S_XOFF;
      end
      S_XOFF: begin
        w_next_state  = S_PAUSED;
        w_refresh_nxt = REFRESH_LOAD;
      end
      S_PAUSED: begin
        // XON wins over a coinciding refresh expiry
        if (w_xon_cond) begin
          w_next_state = S_XON;
        end else if (r_refresh_cnt == 16'd0) begin
          w_next_state = S_XOFF;
        end else begin
          w_refresh_nxt = r_refresh_cnt - 16'd1;
        end
      end
      S_XON: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_pause_xoff = (w_next_state == S_XOFF);
    w_pause_xon  = (w_next_state == S_XON);
    w_paused     = (w_next_state == S_XOFF) || (w_next_state == S_PAUSED);
  end

  eth_sat_cnt u_xoff_cnt (
    .i_clk (clk),
    .i_rst (rst),
    .i_inc (w_pause_xoff),
    .o_cnt (xoff_cnt)
  );

  eth_sat_cnt u_xon_cnt (
    .i_clk (clk),
    .i_rst (rst),
    .i_inc (w_pause_xon),
    .o_cnt (xon_cnt)
  );

  assign sb_to_mac.pause_xoff = r_pause_xoff;
  assign sb_to_mac.pause_xon  = r_pause_xon;
  assign sb_to_mac.pfc_xoff   = r_pfc_xoff;
  assign paused               = r_paused;

endmodule

// File: tb/tb_eth_pause_gen.sv
// tb/tb_eth_pause_gen.sv - scoreboard bench for eth_pause_gen
module tb_eth_pause_gen;
  import ofs_fim_eth_plat_if_pkg::*;

  localparam int R = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 cfg_pause_en = 1'b0;
  logic [7:0]           cfg_pfc_en = '0;
  logic [11:0]          rx_occ = '0;
  logic [7:0]           pfc_req = '0;
  t_eth_sideband_to_mac sb_to_mac;
  logic                 paused;
  logic [31:0]          xoff_cnt;
  logic [31:0]          xon_cnt;

  always #5 clk = ~clk;

  eth_pause_gen #(
    .OCC_WIDTH      (12),
    .XOFF_THRESH    (768),
    .XON_THRESH     (256),
    .REFRESH_CYCLES (R)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_pause_en (cfg_pause_en),
    .cfg_pfc_en   (cfg_pfc_en),
    .rx_occ       (rx_occ),
    .pfc_req      (pfc_req),
    .sb_to_mac    (sb_to_mac),
    .paused       (paused),
    .xoff_cnt     (xoff_cnt),
    .xon_cnt      (xon_cnt)
  );

  typedef struct packed {
    logic        xoff;
    logic        xon;
    logic [7:0]  pfc;
    logic        paused;
    logic [31:0] xc;
    logic [31:0] nc;
  } t_exp;

  t_exp        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          m_state = 0;   // 0 idle, 1 xoff, 2 paused, 3 xon
  int          m_since = 0;   // cycles since the last XOFF pulse
  logic [31:0] m_xoff_cnt = '0;
  logic [31:0] m_xon_cnt = '0;
  int          cyc = 0;
  int          last_xoff = -1;
  int          last_gap = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_push();
    t_exp e;
    int   nxt;
    e = '0;
    if (rst) begin
      m_state    = 0;
      m_since    = 0;
      m_xoff_cnt = '0;
      m_xon_cnt  = '0;
    end else begin
      nxt = m_state;
      case (m_state)
        0: if (cfg_pause_en && rx_occ >= 768) nxt = 1;
        1: nxt = 2;
        2: begin
          if (!cfg_pause_en || rx_occ <= 256) nxt = 3;
          else if (m_since >= R) nxt = 1;
        end
        default: nxt = 0;
      endcase
      m_since = (nxt == 1) ? 0 : m_since + 1;
      if (nxt == 1 && m_xoff_cnt != '1) m_xoff_cnt = m_xoff_cnt + 1;
      if (nxt == 3 && m_xon_cnt != '1) m_xon_cnt = m_xon_cnt + 1;
      m_state  = nxt;
      e.xoff   = (nxt == 1);
      e.xon    = (nxt == 3);
      e.paused = (nxt == 1) || (nxt == 2);
      e.pfc    = pfc_req & cfg_pfc_en;
      e.xc     = m_xoff_cnt;
      e.nc     = m_xon_cnt;
    end
    exp_q.push_back(e);
  endtask

  task automatic cycle();
    t_exp e;
    model_push();
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("pause_xoff", 32'(sb_to_mac.pause_xoff), 32'(e.xoff));
      check("pause_xon", 32'(sb_to_mac.pause_xon), 32'(e.xon));
      check("pfc_xoff", 32'(sb_to_mac.pfc_xoff), 32'(e.pfc));
      check("paused", 32'(paused), 32'(e.paused));
      check("xoff_cnt", xoff_cnt, e.xc);
      check("xon_cnt", xon_cnt, e.nc);
      check("xoff_xon_excl", 32'(sb_to_mac.pause_xoff & sb_to_mac.pause_xon), 32'd0);
    end
    if (sb_to_mac.pause_xoff) begin
      if (last_xoff >= 0) last_gap = cyc - last_xoff;
      last_xoff = cyc;
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_model(input string tag, input int st, input int since, input int budget);
    int k;
    k = 0;
    while (!(m_state == st && m_since == since) && k < budget) begin
      cycle();
      k++;
    end
    if (k >= budget) check(tag, 32'd1, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    run(3);
    check("rst_sb", 32'(sb_to_mac), 32'd0);
    check("rst_xoff_cnt", xoff_cnt, 32'd0);
    rst = 1'b0;
    cfg_pause_en = 1'b1;

    rx_occ = 12'd767;
    run(10);
    rx_occ = 12'd768;
    cycle();
    check("xoff_latency", 32'(sb_to_mac.pause_xoff), 32'd1);
    check("paused_at_xoff", 32'(paused), 32'd1);
    check("first_xoff_cnt", xoff_cnt, 32'd1);

    rx_occ = 12'd800;
    run(51);
    check("refresh_gap", 32'(last_gap), 32'(R + 1));
    check("xoff_cnt_refresh", xoff_cnt, 32'd4);
    check("no_xon_refresh", xon_cnt, 32'd0);
    run(3);

    rx_occ = 12'd500;
    run(5);
    check("hyst_paused", 32'(paused), 32'd1);
    rx_occ = 12'd256;
    cycle();
    check("xon_latency", 32'(sb_to_mac.pause_xon), 32'd1);
    cycle();
    check("idle_after_xon", 32'(paused), 32'd0);
    check("xon_cnt_one", xon_cnt, 32'd1);

    rx_occ = 12'd900;
    wait_model("timeout_simul", 2, R, 60);
    rx_occ = 12'd100;
    cycle();
    check("simul_xon", 32'(sb_to_mac.pause_xon), 32'd1);
    check("simul_xoff_cnt", xoff_cnt, 32'd5);
    run(3);

    rx_occ = 12'd900;
    wait_model("timeout_dis", 2, 3, 60);
    cfg_pause_en = 1'b0;
    cycle();
    check("dis_xon", 32'(sb_to_mac.pause_xon), 32'd1);
    run(25);
    check("dis_no_xoff", xoff_cnt, 32'd6);
    check("dis_xon_cnt", xon_cnt, 32'd3);

    cfg_pause_en = 1'b1;
    wait_model("timeout_rst", 2, 5, 60);
    rst = 1'b1;
    cycle();
    check("rst_mid_sb", 32'(sb_to_mac), 32'd0);
    check("rst_mid_paused", 32'(paused), 32'd0);
    check("rst_mid_xon_cnt", xon_cnt, 32'd0);
    rst = 1'b0;
    rx_occ = 12'd0;
    run(3);

    cfg_pfc_en = 8'h0F;
    pfc_req = 8'hA5;
    cycle();
    check("pfc_a5_0f", 32'(sb_to_mac.pfc_xoff), 32'h05);
    check("pfc_fsm_idle", 32'(paused), 32'd0);
    rx_occ = 12'd900;
    run(4);
    check("pfc_during_pause", 32'(sb_to_mac.pfc_xoff), 32'h05);

    for (int i = 0; i < 40; i++) begin
      rx_occ = 12'($urandom_range(0, 1100));
      cfg_pause_en = ($urandom_range(0, 9) != 0);
      cfg_pfc_en = 8'($urandom);
      for (int j = 0; j < int'($urandom_range(1, 24)); j++) begin
        pfc_req = 8'($urandom);
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
